// File: rtl/mini_mips_isa_pkg.sv
// Shared ISA constants and field-position helpers for the mini MIPS pipeline.
// Instruction layout, MSB to LSB: opcode | rs | rt | rd | func.
// The immediate is the low rd+func bits.
package mini_mips_isa_pkg;

    // Default field widths, giving a 16-bit instruction word.
    localparam int OP_W_DEF   = 4;
    localparam int REG_W_DEF  = 3;
    localparam int FUNC_W_DEF = 3;
    localparam int DATA_W_DEF = 32;

    // Opcode 0 selects the register-register (R-type) format.
    localparam int OPC_RTYPE  = 0;

    // Total instruction width for a given field configuration.
    function automatic int instr_width(input int op_w, input int reg_w, input int func_w);
        return op_w + 3 * reg_w + func_w;
    endfunction

    // Immediate width: the rd and func fields taken together.
    function automatic int imm_width(input int reg_w, input int func_w);
        return reg_w + func_w;
    endfunction

    // LSB position of each field within the instruction word.
    function automatic int op_lsb(input int reg_w, input int func_w);
        return 3 * reg_w + func_w;
    endfunction

    function automatic int rs_lsb(input int reg_w, input int func_w);
        return 2 * reg_w + func_w;
    endfunction

    function automatic int rt_lsb(input int reg_w, input int func_w);
        return reg_w + func_w;
    endfunction

    function automatic int rd_lsb(input int func_w);
        return func_w;
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Bundle between fetch, the decode stage and the register-read stage.
//
// Handshake: on both the input side (in_valid/in_ready) and the output side
// (out_valid/out_ready) a transfer happens on a rising clk edge where valid
// and ready are both 1. A sender holding valid=1 keeps its payload stable
// until the transfer, and never withdraws valid. The stage drives in_ready
// and all of its outputs from registers.
interface instr_decode_stage_if
    import mini_mips_isa_pkg::*;
#(
    parameter int OP_W   = OP_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int FUNC_W = FUNC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    // Fetch side
    logic                                 in_valid;
    logic                                 in_ready;
    logic [OP_W+3*REG_W+FUNC_W-1:0]       in_instr;

    // Register-read side
    logic                                 out_valid;
    logic                                 out_ready;
    logic [OP_W-1:0]                      opcode;
    logic [REG_W-1:0]                     rs;
    logic [REG_W-1:0]                     rt;
    logic [REG_W-1:0]                     rd;
    logic [FUNC_W-1:0]                    func;
    logic [DATA_W-1:0]                    imm_ext;
    logic                                 is_rtype;
    logic [REG_W-1:0]                     dst_reg;
    logic                                 illegal;

    // Environment view: offers instructions and consumes decoded bundles.
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, func,
               imm_ext, is_rtype, dst_reg, illegal
    );

    // Decode stage view.
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, func,
               imm_ext, is_rtype, dst_reg, illegal
    );

endinterface

// File: rtl/instr_field_extract.sv
// Purely combinational split of one instruction word into its fields plus
// derived control (extended immediate, destination register, R-type and
// illegal-opcode flags).
module instr_field_extract
    import mini_mips_isa_pkg::*;
#(
    parameter int                     OP_W       = OP_W_DEF,
    parameter int                     REG_W      = REG_W_DEF,
    parameter int                     FUNC_W     = FUNC_W_DEF,
    parameter int                     DATA_W     = DATA_W_DEF,
    parameter logic [2**OP_W-1:0]     ZEXT_MASK  = '0,
    parameter logic [2**OP_W-1:0]     LEGAL_MASK = '1
) (
    input  logic [OP_W+3*REG_W+FUNC_W-1:0] instr,
    output logic [OP_W-1:0]                opcode,
    output logic [REG_W-1:0]               rs,
    output logic [REG_W-1:0]               rt,
    output logic [REG_W-1:0]               rd,
    output logic [FUNC_W-1:0]              func,
    output logic [DATA_W-1:0]              imm_ext,
    output logic                           is_rtype,
    output logic [REG_W-1:0]               dst_reg,
    output logic                           illegal
);

    localparam int IMM_W   = imm_width(REG_W, FUNC_W);
    localparam int OP_LSB  = op_lsb(REG_W, FUNC_W);
    localparam int RS_LSB  = rs_lsb(REG_W, FUNC_W);
    localparam int RT_LSB  = rt_lsb(REG_W, FUNC_W);
    localparam int RD_LSB  = rd_lsb(FUNC_W);

    logic [IMM_W-1:0] imm;

    // Raw field slices.
    assign opcode = instr[OP_LSB +: OP_W];
    assign rs     = instr[RS_LSB +: REG_W];
    assign rt     = instr[RT_LSB +: REG_W];
    assign rd     = instr[RD_LSB +: REG_W];
    assign func   = instr[FUNC_W-1:0];
    assign imm    = instr[IMM_W-1:0];

    // Derived control: R-type writes rd, every other format writes rt.
    assign is_rtype = (opcode == OP_W'(OPC_RTYPE));
    assign dst_reg  = is_rtype ? rd : rt;
    assign illegal  = !LEGAL_MASK[opcode];

    // Immediate extension; the fill bit is 0 for zero-extending opcodes,
    // otherwise the immediate's top bit.
    generate
        if (DATA_W > IMM_W) begin : g_ext
            logic fill;
            assign fill    = ZEXT_MASK[opcode] ? 1'b0 : imm[IMM_W-1];
            assign imm_ext = {{(DATA_W-IMM_W){fill}}, imm};
        end else begin : g_noext
            assign imm_ext = imm;
        end
    endgenerate

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage. Two raw-instruction registers: main
// (drives the decoded outputs) and skid (absorbs one word when the consumer
// stalls), so in_ready can be a plain register with no combinational path
// from out_ready.
module instr_decode_stage
    import mini_mips_isa_pkg::*;
#(
    parameter int                     OP_W       = OP_W_DEF,
    parameter int                     REG_W      = REG_W_DEF,
    parameter int                     FUNC_W     = FUNC_W_DEF,
    parameter int                     DATA_W     = DATA_W_DEF,
    parameter logic [2**OP_W-1:0]     ZEXT_MASK  = '0,
    parameter logic [2**OP_W-1:0]     LEGAL_MASK = '1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    instr_decode_stage_if.slave       bus
);

    localparam int INSTR_W = instr_width(OP_W, REG_W, FUNC_W);

    logic [INSTR_W-1:0] main_q;
    logic [INSTR_W-1:0] main_d;
    logic [INSTR_W-1:0] skid_q;
    logic [INSTR_W-1:0] skid_d;
    logic               main_v_q;
    logic               main_v_d;
    logic               skid_v_q;
    logic               skid_v_d;
    logic               in_ready_q;
    logic               in_acc;
    logic               out_acc;

    assign in_acc  = bus.in_valid & in_ready_q;
    assign out_acc = main_v_q & bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_v_q;

    // Next-state for the two buffers. Flush wins over every transfer; a
    // word accepted while skid is full cannot happen since in_ready is 0.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            if (out_acc) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (in_acc) begin
            if (!main_v_q || out_acc) begin
                main_d   = bus.in_instr;
                main_v_d = 1'b1;
            end else begin
                skid_d   = bus.in_instr;
                skid_v_d = 1'b1;
            end
        end else if (out_acc) begin
            main_v_d = 1'b0;
        end
    end

    // Buffer registers; in_ready tracks the next skid occupancy so it is
    // always the registered complement of skid_valid (0 only in reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= !skid_v_d;
        end
    end

    instr_field_extract #(
        .OP_W       (OP_W),
        .REG_W      (REG_W),
        .FUNC_W     (FUNC_W),
        .DATA_W     (DATA_W),
        .ZEXT_MASK  (ZEXT_MASK),
        .LEGAL_MASK (LEGAL_MASK)
    ) u_extract (
        .instr    (main_q),
        .opcode   (bus.opcode),
        .rs       (bus.rs),
        .rt       (bus.rt),
        .rd       (bus.rd),
        .func     (bus.func),
        .imm_ext  (bus.imm_ext),
        .is_rtype (bus.is_rtype),
        .dst_reg  (bus.dst_reg),
        .illegal  (bus.illegal)
    );

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: three builds (default, op4 zero-extending,
// op15 illegal) driven with identical stimulus.
module tb_instr_decode_stage;

    localparam int OP_W   = 4;
    localparam int REG_W  = 3;
    localparam int FUNC_W = 3;
    localparam int DATA_W = 32;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_instr  = 16'h0000;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] src_q[$];

    typedef struct {
        logic [15:0] instr;
        logic [31:0] op, rs, rt, rd, func, imm, rtype, dst, ill, imm_z, ill_l;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    instr_decode_stage_if #(.OP_W(OP_W), .REG_W(REG_W), .FUNC_W(FUNC_W), .DATA_W(DATA_W)) bus_a ();
    instr_decode_stage_if #(.OP_W(OP_W), .REG_W(REG_W), .FUNC_W(FUNC_W), .DATA_W(DATA_W)) bus_z ();
    instr_decode_stage_if #(.OP_W(OP_W), .REG_W(REG_W), .FUNC_W(FUNC_W), .DATA_W(DATA_W)) bus_l ();

    assign bus_a.in_valid = in_valid;  assign bus_a.in_instr = in_instr;  assign bus_a.out_ready = out_ready;
    assign bus_z.in_valid = in_valid;  assign bus_z.in_instr = in_instr;  assign bus_z.out_ready = out_ready;
    assign bus_l.in_valid = in_valid;  assign bus_l.in_instr = in_instr;  assign bus_l.out_ready = out_ready;

    instr_decode_stage #(.OP_W(OP_W), .REG_W(REG_W), .FUNC_W(FUNC_W), .DATA_W(DATA_W))
        dut_a (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a));
    instr_decode_stage #(.OP_W(OP_W), .REG_W(REG_W), .FUNC_W(FUNC_W), .DATA_W(DATA_W),
                         .ZEXT_MASK(16'h0010))
        dut_z (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_z));
    instr_decode_stage #(.OP_W(OP_W), .REG_W(REG_W), .FUNC_W(FUNC_W), .DATA_W(DATA_W),
                         .LEGAL_MASK(16'h7FFF))
        dut_l (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_l));

    logic [15:0] out_word;
    assign out_word = {bus_a.opcode, bus_a.rs, bus_a.rt, bus_a.rd, bus_a.func};

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v);
        check("vec_out_valid", 32'(bus_a.out_valid), 32'd1);
        check("vec_opcode",    32'(bus_a.opcode),    v.op);
        check("vec_rs",        32'(bus_a.rs),        v.rs);
        check("vec_rt",        32'(bus_a.rt),        v.rt);
        check("vec_rd",        32'(bus_a.rd),        v.rd);
        check("vec_func",      32'(bus_a.func),      v.func);
        check("vec_imm_ext",   bus_a.imm_ext,        v.imm);
        check("vec_is_rtype",  32'(bus_a.is_rtype),  v.rtype);
        check("vec_dst_reg",   32'(bus_a.dst_reg),   v.dst);
        check("vec_illegal",   32'(bus_a.illegal),   v.ill);
        check("vec_imm_zext",  bus_z.imm_ext,        v.imm_z);
        check("vec_illegal_l", 32'(bus_l.illegal),   v.ill_l);
    endtask

    // Producer/consumer loop on src_q/exp_q. out_ready is held low for the
    // first 'stall' cycles; while stalled the output must hold hold_word and,
    // from the third cycle, in_ready must be 0 (main and skid both full).
    task automatic stream(input int stall, input logic [15:0] hold_word, input int budget);
        int cyc = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            if (src_q.size() > 0) begin
                in_valid = 1'b1;
                in_instr = src_q[0];
            end else begin
                in_valid = 1'b0;
            end
            if (cyc >= 1 && cyc < stall) begin
                check("hold_valid", 32'(bus_a.out_valid), 32'd1);
                check("hold_word",  32'(out_word), 32'(hold_word));
            end
            if (cyc >= 2 && cyc < stall)
                check("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
            if (in_valid && bus_a.in_ready)
                void'(src_q.pop_front());
            if (bus_a.out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_delivery", 32'd1, 32'd0);
                else                   check("deliver", 32'(out_word), 32'(exp_q.pop_front()));
            end
            cyc++;
        end
        check("stream_drained", 32'(exp_q.size() + src_q.size()), 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h029C, 0, 1, 2, 3, 4, 32'h0000001C, 1, 3, 0, 32'h0000001C, 0};
        vecs[1] = '{16'h457E, 4, 2, 5, 7, 6, 32'hFFFFFFFE, 0, 5, 0, 32'h0000003E, 0};
        vecs[2] = '{16'hF000, 15, 0, 0, 0, 0, 32'h00000000, 0, 0, 0, 32'h00000000, 1};
        vecs[3] = '{16'h1000, 1, 0, 0, 0, 0, 32'h00000000, 0, 0, 0, 32'h00000000, 0};
        vecs[4] = '{16'h3FFF, 3, 7, 7, 7, 7, 32'hFFFFFFFF, 0, 7, 0, 32'hFFFFFFFF, 0};
        vecs[5] = '{16'h0020, 0, 0, 0, 4, 0, 32'hFFFFFFE0, 1, 4, 0, 32'hFFFFFFE0, 0};
        vecs[6] = '{16'h4420, 4, 2, 0, 4, 0, 32'hFFFFFFE0, 0, 0, 0, 32'h00000020, 0};
        vecs[7] = '{16'h401F, 4, 0, 0, 3, 7, 32'h0000001F, 0, 0, 0, 32'h0000001F, 0};
        vecs[8] = '{16'h8A40, 8, 5, 1, 0, 0, 32'h00000000, 0, 1, 0, 32'h00000000, 0};

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus_a.in_ready),  32'd0);
        check("rst_opcode",    32'(bus_a.opcode),    32'd0);
        check("rst_imm_ext",   bus_a.imm_ext,        32'd0);
        check("rst_is_rtype",  32'(bus_a.is_rtype),  32'd1);
        check("rst_dst_reg",   32'(bus_a.dst_reg),   32'd0);
        check("rst_illegal",   32'(bus_a.illegal),   32'd0);
        check("rst_illegal_l", 32'(bus_l.illegal),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus_a.in_ready), 32'd1);

        // Table: one vector per cycle, consumer always ready
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_vec(vecs[i-1]);
                check("vec_in_ready", 32'(bus_a.in_ready), 32'd1);
            end
            if (i < NV) begin
                in_valid  = 1'b1;
                in_instr  = vecs[i].instr;
                out_ready = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("table_drained", 32'(bus_a.out_valid), 32'd0);

        // Backpressure: A, B, C offered back-to-back with consumer stalled
        src_q = '{16'h029C, 16'h457E, 16'h1000};
        exp_q = '{16'h029C, 16'h457E, 16'h1000};
        stream(4, 16'h029C, 40);
        @(negedge clk);
        check("bp_empty_after", 32'(bus_a.out_valid), 32'd0);

        // Flush with main and skid full and a word offered alongside
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h3FFF;
        @(negedge clk);
        in_instr  = 16'h4420;
        @(negedge clk);
        check("pre_flush_in_ready",  32'(bus_a.in_ready),  32'd0);
        check("pre_flush_out_valid", 32'(bus_a.out_valid), 32'd1);
        flush    = 1'b1;
        in_instr = 16'h1000;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("flush_in_ready",  32'(bus_a.in_ready),  32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_stays_empty", 32'(bus_a.out_valid), 32'd0);
        end
        src_q = '{16'h8A40};
        exp_q = '{16'h8A40};
        stream(0, 16'h0000, 10);
        @(negedge clk);
        check("post_flush_empty", 32'(bus_a.out_valid), 32'd0);

        // Asynchronous reset while holding two words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h3FFF;
        @(negedge clk);
        in_instr  = 16'h4420;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_in_ready", 32'(bus_a.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("async_rst_in_ready",  32'(bus_a.in_ready),  32'd0);
        check("async_rst_word",      32'(out_word),        32'd0);
        check("async_rst_is_rtype",  32'(bus_a.is_rtype),  32'd1);
        @(negedge clk);
        check("held_rst_in_ready", 32'(bus_a.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_in_ready",  32'(bus_a.in_ready),  32'd1);
        check("rerelease_out_valid", 32'(bus_a.out_valid), 32'd0);
        in_valid  = 1'b1;
        in_instr  = 16'h457E;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_vec(vecs[1]);
        @(negedge clk);
        check("final_empty", 32'(bus_a.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
